// File: rtl/button_debouncer_n.sv
// Multi-channel button debouncer: synchroniser, shared tick prescaler, per-channel confirm FSM.
// Define DEBOUNCE_EDGE_EN to add press_pulse/release_pulse strobe outputs.
module button_debouncer_n #(
  parameter int CHANNELS     = 4,
  parameter int TICK_DIV     = 12000,
  parameter int STABLE_TICKS = 10,
  parameter int SYNC_STAGES  = 2,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic                clock_in,
  input  logic                reset,
  input  logic [CHANNELS-1:0] button_in,
  output logic [CHANNELS-1:0] button_out
`ifdef DEBOUNCE_EDGE_EN
  ,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse
`endif
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);

  typedef enum logic {
    ST_STABLE,
    ST_CONFIRM
  } state_t;

  logic [PW-1:0]       pre_q;
  logic                tick;
  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_last;
  logic [CHANNELS-1:0] s;
  logic [CHANNELS-1:0] flip;

  assign tick = (pre_q == PW'(TICK_DIV - 1));

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
    end else if (tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PW'(1);
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= button_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign s = (ACTIVE_LOW != 0) ? ~sync_last : sync_last;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          flip_d;

    always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
        state_q <= ST_STABLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Reversion is checked before the tick, so a glitch on a tick cycle never counts.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      flip_d  = 1'b0;
      unique case (state_q)
        ST_STABLE: begin
          if (s[i] != button_out[i]) begin
            state_d = ST_CONFIRM;
            cnt_d   = '0;
          end
        end
        ST_CONFIRM: begin
          if (s[i] == button_out[i]) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (tick) begin
            if (cnt_q == CW'(STABLE_TICKS - 1)) begin
              flip_d  = 1'b1;
              state_d = ST_STABLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
      endcase
    end

    assign flip[i] = flip_d;
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      button_out <= '0;
    end else begin
      button_out <= button_out ^ flip;
    end
  end

`ifdef DEBOUNCE_EDGE_EN
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      press_pulse   <= '0;
      release_pulse <= '0;
    end else begin
      press_pulse   <= flip & ~button_out;
      release_pulse <= flip & button_out;
    end
  end
`endif

endmodule

// File: tb/tb_button_debouncer_n.sv
// Directed bench for button_debouncer_n (2 channels, TICK_DIV=4, STABLE_TICKS=3).
// A second instance exercises ACTIVE_LOW=1.
module tb_button_debouncer_n;

  logic       clock_in = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] button_in = 2'b00;
  logic [1:0] button_out;
  logic [1:0] bin_al = 2'b11;
  logic [1:0] bout_al;
`ifdef DEBOUNCE_EDGE_EN
  logic [1:0] press_pulse;
  logic [1:0] release_pulse;
  logic [1:0] press_al;
  logic [1:0] release_al;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clock_in = ~clock_in;

  button_debouncer_n #(
    .CHANNELS(2), .TICK_DIV(4), .STABLE_TICKS(3),
    .SYNC_STAGES(2), .ACTIVE_LOW(0)
  ) dut (
    .clock_in(clock_in),
    .reset(reset),
    .button_in(button_in),
    .button_out(button_out)
`ifdef DEBOUNCE_EDGE_EN
    ,
    .press_pulse(press_pulse),
    .release_pulse(release_pulse)
`endif
  );

  button_debouncer_n #(
    .CHANNELS(2), .TICK_DIV(4), .STABLE_TICKS(3),
    .SYNC_STAGES(2), .ACTIVE_LOW(1)
  ) dut_al (
    .clock_in(clock_in),
    .reset(reset),
    .button_in(bin_al),
    .button_out(bout_al)
`ifdef DEBOUNCE_EDGE_EN
    ,
    .press_pulse(press_al),
    .release_pulse(release_al)
`endif
  );

  // Reset released 1ns after edge E0; ticks then land on E4, E8, E12 ...
  task automatic do_reset();
    @(posedge clock_in); #1;
    reset = 1'b1;
    repeat (2) @(posedge clock_in);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clock_in); #1;
    end
  endtask

  task automatic test_reset();
    button_in = 2'b00;
    bin_al = 2'b11;
    @(posedge clock_in); #1;
    reset = 1'b1;
    @(posedge clock_in); #1;
    checks++;
    if (button_out !== 2'b00 || bout_al !== 2'b00) begin
      errors++;
      $display("FAIL reset_hold out=%b al=%b exp=00", button_out, bout_al);
    end
    @(posedge clock_in); #1;
    reset = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clock_in); #1;
      checks++;
      if (button_out !== 2'b00 || bout_al !== 2'b00) begin
        errors++;
        $display("FAIL idle k=%0d out=%b al=%b exp=00", k, button_out, bout_al);
      end
`ifdef DEBOUNCE_EDGE_EN
      checks++;
      if ({press_pulse, release_pulse, press_al, release_al} !== 8'h00) begin
        errors++;
        $display("FAIL idle_pulse k=%0d p=%b r=%b exp=00", k, press_pulse, release_pulse);
      end
`endif
    end
  endtask

  task automatic test_press();
    button_in = 2'b00;
    do_reset();
    wait_cycles(4);
    button_in = 2'b01;
    for (int k = 1; k <= 20; k++) begin
      logic [1:0] exp_out;
      @(posedge clock_in); #1;
      exp_out = (k >= 12) ? 2'b01 : 2'b00;
      checks++;
      if (button_out !== exp_out) begin
        errors++;
        $display("FAIL press k=%0d out=%b exp=%b", k, button_out, exp_out);
      end
`ifdef DEBOUNCE_EDGE_EN
      checks++;
      if (press_pulse !== ((k == 12) ? 2'b01 : 2'b00) || release_pulse !== 2'b00) begin
        errors++;
        $display("FAIL press_pulse k=%0d p=%b r=%b", k, press_pulse, release_pulse);
      end
`endif
    end
  endtask

  task automatic test_bounce();
    button_in = 2'b00;
    do_reset();
    wait_cycles(4);
    button_in = 2'b10;
    wait_cycles(6);
    button_in = 2'b00;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clock_in); #1;
      checks++;
      if (button_out !== 2'b00) begin
        errors++;
        $display("FAIL bounce k=%0d out=%b exp=00", k, button_out);
      end
`ifdef DEBOUNCE_EDGE_EN
      checks++;
      if (press_pulse !== 2'b00) begin
        errors++;
        $display("FAIL bounce_pulse k=%0d p=%b exp=00", k, press_pulse);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    button_in = 2'b00;
    do_reset();
    wait_cycles(4);
    button_in = 2'b11;
    for (int k = 1; k <= 20; k++) begin
      logic [1:0] exp_out;
      @(posedge clock_in); #1;
      exp_out = (k >= 12) ? 2'b11 : 2'b00;
      checks++;
      if (button_out !== exp_out) begin
        errors++;
        $display("FAIL both_rise k=%0d out=%b exp=%b", k, button_out, exp_out);
      end
`ifdef DEBOUNCE_EDGE_EN
      checks++;
      if (press_pulse !== ((k == 12) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL both_press k=%0d p=%b", k, press_pulse);
      end
`endif
    end
    button_in = 2'b00;
    for (int k = 1; k <= 20; k++) begin
      logic [1:0] exp_out;
      @(posedge clock_in); #1;
      exp_out = (k >= 12) ? 2'b00 : 2'b11;
      checks++;
      if (button_out !== exp_out) begin
        errors++;
        $display("FAIL both_fall k=%0d out=%b exp=%b", k, button_out, exp_out);
      end
`ifdef DEBOUNCE_EDGE_EN
      checks++;
      if (release_pulse !== ((k == 12) ? 2'b11 : 2'b00) || press_pulse !== 2'b00) begin
        errors++;
        $display("FAIL both_release k=%0d p=%b r=%b", k, press_pulse, release_pulse);
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    button_in = 2'b00;
    do_reset();
    wait_cycles(4);
    button_in = 2'b01;
    wait_cycles(9);
    reset = 1'b1;
    #1;
    checks++;
    if (button_out !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset out=%b exp=00", button_out);
    end
    repeat (2) @(posedge clock_in);
    #1;
    reset = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      logic [1:0] exp_out;
      @(posedge clock_in); #1;
      exp_out = (k >= 12) ? 2'b01 : 2'b00;
      checks++;
      if (button_out !== exp_out) begin
        errors++;
        $display("FAIL requal k=%0d out=%b exp=%b", k, button_out, exp_out);
      end
    end
  endtask

  task automatic test_active_low();
    button_in = 2'b00;
    bin_al = 2'b11;
    do_reset();
    for (int k = 1; k <= 32; k++) begin
      @(posedge clock_in); #1;
      checks++;
      if (bout_al !== 2'b00) begin
        errors++;
        $display("FAIL al_idle k=%0d out=%b exp=00", k, bout_al);
      end
`ifdef DEBOUNCE_EDGE_EN
      checks++;
      if (press_al !== 2'b00 || release_al !== 2'b00) begin
        errors++;
        $display("FAIL al_pulse k=%0d p=%b r=%b", k, press_al, release_al);
      end
`endif
    end
    bin_al = 2'b10;
    for (int k = 1; k <= 14; k++) begin
      logic [1:0] exp_out;
      @(posedge clock_in); #1;
      exp_out = (k >= 12) ? 2'b01 : 2'b00;
      checks++;
      if (bout_al !== exp_out) begin
        errors++;
        $display("FAIL al_press k=%0d out=%b exp=%b", k, bout_al, exp_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_back_to_back();
    test_reset_mid();
    test_active_low();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
